aes_key_expander_seq: RTL and testbench

- Iterative, runtime-configurable AES key schedule generator for AES-128, AES-192 and AES-256.
- Produces one 32-bit schedule word per clock using a single shared subword instance, so area is much smaller than a fully unrolled combinational expansion.
- Stores the full schedule, up to 60 words, and exposes any 128-bit round key through a random-access read port.
- Sits between key load logic and the iterative cipher/inverse-cipher round datapaths.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_subword.sv | 14 +
 rtl/aes_key_expander_seq.sv | 204 ++++++++++++++++++++
 tb/tb_aes_key_expander_seq.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length modes, per-mode schedule sizes and GF(2^8)
// helpers used by the key expander and its S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_AES128  = 2'b00,
    KL_AES192  = 2'b01,
    KL_AES256  = 2'b10,
    KL_ILLEGAL = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } kexp_state_e;

  localparam int WIDX_W = 6;

  localparam logic [3:0]        NK_AES128 = 4'd4;
  localparam logic [3:0]        NK_AES192 = 4'd6;
  localparam logic [3:0]        NK_AES256 = 4'd8;
  localparam logic [3:0]        NR_AES128 = 4'd10;
  localparam logic [3:0]        NR_AES192 = 4'd12;
  localparam logic [3:0]        NR_AES256 = 4'd14;
  localparam logic [WIDX_W-1:0] W_AES128  = 6'd44;
  localparam logic [WIDX_W-1:0] W_AES192  = 6'd52;
  localparam logic [WIDX_W-1:0] W_AES256  = 6'd60;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] a_v;
    logic [7:0] p_v;
    a_v = a;
    p_v = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p_v = p_v ^ (b[k] ? a_v : 8'h00);
      a_v = xtime(a_v);
    end
    return p_v;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r_v;
    r_v = 8'h01;
    for (int k = 0; k < 7; k++) begin
      r_v = gf_mul(gf_mul(r_v, r_v), x);
    end
    r_v = gf_mul(r_v, r_v);
    return r_v ^ {r_v[6:0], r_v[7]} ^ {r_v[5:0], r_v[7:6]} ^
           {r_v[4:0], r_v[7:5]} ^ {r_v[3:0], r_v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES forward S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = sbox(in_i);

endmodule

// File: rtl/aes_subword.sv
// SubWord: applies the S-box to each of the four bytes of a 32-bit word.
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .in_i  (word_i[8*b +: 8]),
      .out_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock through a single
// SubWord instance, full schedule kept in storage behind a round-key read port.
module aes_key_expander_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [0:32*MAX_NK-1]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [RK_IDX_W-1:0]   rk_idx,
  output logic [0:127]          rk_out,
  output logic                  rk_valid
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  kexp_state_e       state_q, state_d;
  logic [3:0]        nk_q, nk_d, nr_q, nr_d;
  logic [WIDX_W-1:0] total_q, total_d, i_q, i_d;
  logic [2:0]        wrap_q, wrap_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              sched_ok_q, sched_ok_d;
  logic [31:0]       w_q [DEPTH];

  logic [3:0]        mode_nk_s, mode_nr_s;
  logic [WIDX_W-1:0] mode_w_s;
  logic              mode_legal_s;
  logic              load_s, wr_s, rot_sel_s, rk_valid_s;
  logic [31:0]       prev_s, back_s, sub_in_s, sub_out_s, new_w_s;
  logic [WIDX_W-1:0] rd_base_s;

  // Mode decode; a key length longer than the storage supports is illegal
  always_comb begin
    mode_nk_s    = 4'd0;
    mode_nr_s    = 4'd0;
    mode_w_s     = 6'd0;
    mode_legal_s = 1'b0;
    case (key_len)
      KL_AES128: begin
        mode_nk_s = NK_AES128; mode_nr_s = NR_AES128; mode_w_s = W_AES128;
        mode_legal_s = (int'(NK_AES128) <= MAX_NK);
      end
      KL_AES192: begin
        mode_nk_s = NK_AES192; mode_nr_s = NR_AES192; mode_w_s = W_AES192;
        mode_legal_s = (int'(NK_AES192) <= MAX_NK);
      end
      KL_AES256: begin
        mode_nk_s = NK_AES256; mode_nr_s = NR_AES256; mode_w_s = W_AES256;
        mode_legal_s = (int'(NK_AES256) <= MAX_NK);
      end
      default: mode_legal_s = 1'b0;
    endcase
  end

  // Next schedule word; wrap_q tracks i mod nk
  always_comb begin
    prev_s    = w_q[i_q - 6'd1];
    back_s    = w_q[i_q - {2'b00, nk_q}];
    rot_sel_s = (wrap_q == 3'd0);
    sub_in_s  = rot_sel_s ? rotword(prev_s) : prev_s;
    if (rot_sel_s) begin
      new_w_s = back_s ^ sub_out_s ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (wrap_q == 3'd4)) begin
      new_w_s = back_s ^ sub_out_s;
    end else begin
      new_w_s = prev_s ^ back_s;
    end
  end

  aes_subword u_subword (
    .word_i (sub_in_s),
    .word_o (sub_out_s)
  );

  // FSM next-state, counters and handshake outputs
  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    total_d    = total_q;
    i_d        = i_q;
    wrap_d     = wrap_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sched_ok_d = sched_ok_q;
    load_s     = 1'b0;
    wr_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && mode_legal_s) begin
          load_s     = 1'b1;
          nk_d       = mode_nk_s;
          nr_d       = mode_nr_s;
          total_d    = mode_w_s;
          i_d        = {2'b00, mode_nk_s};
          wrap_d     = 3'd0;
          rcon_d     = 8'h01;
          busy_d     = 1'b1;
          sched_ok_d = 1'b0;
          state_d    = ST_EXPAND;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        wr_s   = 1'b1;
        busy_d = 1'b1;
        i_d    = i_q + 6'd1;
        wrap_d = (wrap_q == 3'(nk_q - 4'd1)) ? 3'd0 : wrap_q + 3'd1;
        rcon_d = rot_sel_s ? xtime(rcon_q) : rcon_q;
        if (i_q == total_q - 6'd1) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          sched_ok_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_EXPAND;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nk_q       <= 4'd0;
      nr_q       <= 4'd0;
      total_q    <= 6'd0;
      i_q        <= 6'd0;
      wrap_q     <= 3'd0;
      rcon_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sched_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      total_q    <= total_d;
      i_q        <= i_d;
      wrap_q     <= wrap_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sched_ok_q <= sched_ok_d;
    end
  end

  // Schedule storage, no reset: contents are only visible once sched_ok is set
  always_ff @(posedge clk) begin
    if (load_s) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(mode_nk_s)) begin
          w_q[j] <= key[32*j +: 32];
        end
      end
    end else if (wr_s) begin
      w_q[i_q] <= new_w_s;
    end
  end

  // Round-key read port; address clamped so invalid indices never reach storage
  always_comb begin
    rk_valid_s = sched_ok_q & (int'(rk_idx) <= int'(nr_q));
    if (rk_valid_s) begin
      rd_base_s = 6'(int'(rk_idx) * 4);
      rk_out    = {w_q[rd_base_s], w_q[rd_base_s + 6'd1],
                   w_q[rd_base_s + 6'd2], w_q[rd_base_s + 6'd3]};
    end else begin
      rd_base_s = 6'd0;
      rk_out    = 128'h0;
    end
  end

  assign rk_valid = rk_valid_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq against a FIPS-197 style model.
module tb_aes_key_expander_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [0:255] key = '0;
  logic         busy, done, err, rk_valid;
  logic [3:0]   rk_idx = 4'd0;
  logic [0:127] rk_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sbox_t [256];
  logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] ref_w  [60];

  localparam logic [0:255] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expander_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .rk_idx(rk_idx), .rk_out(rk_out),
    .rk_valid(rk_valid)
  );

  always #10 clk = ~clk;

  // S-box table from the generator-3 walk over GF(2^8)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [0:255] k);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) ref_w[i] = k[32*i +: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [0:127] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  function automatic logic [0:255] rand_key();
    logic [0:255] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  // Drive one start pulse; returns just after the accepting edge
  task automatic kick(input logic [1:0] len, input logic [0:255] k);
    @(negedge clk);
    key_len = len;
    key     = k;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the start edge until done, bounded
  task automatic wait_done(output int done_at, output int busy_cnt);
    done_at  = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_at = n;
    end
  endtask

  task automatic read_rk(input int r, output logic [0:127] v, output logic vld);
    rk_idx = 4'(r);
    #1;
    v   = rk_out;
    vld = rk_valid;
  endtask

  task automatic test_reset();
    logic [0:127] v; logic vld;
    #3;
    read_rk(0, v, vld);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b want 0", vld); end
    checks++; if (v !== 128'h0) begin errors++; $display("FAIL reset_rk_out got %h want 0", v); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_aes128();
    int d, b; logic [0:127] v; logic vld;
    model_expand(4, KEY128);
    kick(2'b00, KEY128);
    wait_done(d, b);
    checks++; if (d !== 41) begin errors++; $display("FAIL a128_done_cycle got %0d want 41", d); end
    checks++; if (b !== 40) begin errors++; $display("FAIL a128_busy_cycles got %0d want 40", b); end
    read_rk(0, v, vld);
    checks++; if (v !== 128'h2b7e151628aed2a6abf7158809cf4f3c || vld !== 1'b1) begin
      errors++; $display("FAIL a128_rk0 got %h/%b want 2b7e151628aed2a6abf7158809cf4f3c/1", v, vld); end
    read_rk(10, v, vld);
    checks++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL a128_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL a128_done_pulse got %b want 0", done); end
    read_rk(11, v, vld);
    checks++; if (vld !== 1'b0 || v !== 128'h0) begin
      errors++; $display("FAIL a128_rk11 got %h/%b want 0/0", v, vld); end
    for (int r = 0; r <= 10; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL a128_model_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
  endtask

  task automatic test_aes192();
    int d, b; logic [0:127] v; logic vld;
    model_expand(6, KEY192);
    kick(2'b01, KEY192);
    wait_done(d, b);
    checks++; if (d !== 47) begin errors++; $display("FAIL a192_done_cycle got %0d want 47", d); end
    read_rk(12, v, vld);
    checks++; if (v !== 128'he98ba06f448c773c8ecc720401002202 || vld !== 1'b1) begin
      errors++; $display("FAIL a192_rk12 got %h/%b want e98ba06f448c773c8ecc720401002202/1", v, vld); end
    for (int r = 0; r <= 12; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL a192_model_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
  endtask

  task automatic test_aes256();
    int d, b; logic [0:127] v; logic vld;
    model_expand(8, KEY256);
    kick(2'b10, KEY256);
    wait_done(d, b);
    checks++; if (d !== 53) begin errors++; $display("FAIL a256_done_cycle got %0d want 53", d); end
    read_rk(14, v, vld);
    checks++; if (v !== 128'hfe4890d1e6188d0b046df344706c631e || vld !== 1'b1) begin
      errors++; $display("FAIL a256_rk14 got %h/%b want fe4890d1e6188d0b046df344706c631e/1", v, vld); end
    for (int r = 0; r <= 14; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL a256_model_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
  endtask

  // Runs after AES-256: the rejected start must leave that schedule readable
  task automatic test_illegal();
    logic [0:127] v; logic vld;
    kick(2'b11, rand_key());
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_err got err=%b busy=%b want 1/0", err, busy); end
    @(posedge clk);
    #1;
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_err_pulse got err=%b busy=%b want 0/0", err, busy); end
    read_rk(14, v, vld);
    checks++; if (v !== 128'hfe4890d1e6188d0b046df344706c631e || vld !== 1'b1) begin
      errors++; $display("FAIL illegal_keeps_sched got %h/%b want fe4890d1e6188d0b046df344706c631e/1", v, vld); end
  endtask

  task automatic test_ignore_midrun();
    int d, b, err_seen; logic [0:127] v; logic vld; logic [0:255] ka;
    ka = rand_key();
    model_expand(4, ka);
    kick(2'b00, ka);
    d = -1; b = 0; err_seen = 0;
    for (int n = 1; n <= 200 && d < 0; n++) begin
      @(negedge clk);
      if (err) err_seen++;
      if (done) d = n;
      if (n == 10) begin start = 1'b1; key_len = 2'b10; key = rand_key(); end
      else start = 1'b0;
    end
    checks++; if (d !== 41) begin errors++; $display("FAIL midrun_done_cycle got %0d want 41", d); end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL midrun_no_err got %0d want 0", err_seen); end
    for (int r = 0; r <= 10; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL midrun_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
    read_rk(11, v, vld);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL midrun_rk11_valid got %b want 0", vld); end
  endtask

  task automatic test_reset_abort();
    int d, b; logic [0:127] v; logic vld; logic [0:255] k;
    kick(2'b10, rand_key());
    repeat (20) @(negedge clk);
    rk_idx = 4'd0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL abort_async got busy=%b done=%b rk_valid=%b want 0/0/0", busy, done, rk_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle got busy=%b rk_valid=%b want 0/0", busy, rk_valid); end
    k = rand_key();
    model_expand(4, k);
    kick(2'b00, k);
    wait_done(d, b);
    checks++; if (d !== 41) begin errors++; $display("FAIL abort_restart_done got %0d want 41", d); end
    for (int r = 0; r <= 10; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL abort_restart_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
  endtask

  task automatic test_back_to_back();
    int d, b, early; logic [0:127] v; logic vld; logic [0:255] k;
    kick(2'b10, rand_key());
    wait_done(d, b);
    checks++; if (d !== 53) begin errors++; $display("FAIL b2b_first_done got %0d want 53", d); end
    k = rand_key();
    model_expand(4, k);
    kick(2'b00, k);
    d = -1; early = 0;
    for (int n = 1; n <= 200 && d < 0; n++) begin
      @(negedge clk);
      rk_idx = 4'($urandom_range(0, 10));
      #1;
      if (done) d = n;
      else if (rk_valid) early++;
    end
    checks++; if (d !== 41) begin errors++; $display("FAIL b2b_second_done got %0d want 41", d); end
    checks++; if (early !== 0) begin errors++; $display("FAIL b2b_valid_during_expand got %0d want 0", early); end
    for (int r = 11; r <= 14; r++) begin
      read_rk(r, v, vld);
      checks++; if (vld !== 1'b0 || v !== 128'h0) begin
        errors++; $display("FAIL b2b_rk%0d_invalid got %h/%b want 0/0", r, v, vld); end
    end
    for (int r = 0; r <= 10; r++) begin
      read_rk(r, v, vld);
      checks++; if (v !== ref_rk(r)) begin errors++; $display("FAIL b2b_rk%0d got %h want %h", r, v, ref_rk(r)); end
    end
  endtask

  task automatic test_random();
    int d, b, nk, nr; logic [1:0] len; logic [0:127] v; logic vld; logic [0:255] k;
    for (int it = 0; it < 6; it++) begin
      len = 2'(it % 3);
      nk  = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
      nr  = nk + 6;
      k   = rand_key();
      model_expand(nk, k);
      kick(len, k);
      wait_done(d, b);
      checks++; if (d !== 4*(nr+1) - nk + 1) begin
        errors++; $display("FAIL rand%0d_done got %0d want %0d", it, d, 4*(nr+1) - nk + 1); end
      for (int r = 0; r <= 15; r++) begin
        read_rk(r, v, vld);
        checks++;
        if (r <= nr && (v !== ref_rk(r) || vld !== 1'b1)) begin
          errors++; $display("FAIL rand%0d_rk%0d got %h/%b want %h/1", it, r, v, vld, ref_rk(r)); end
        else if (r > nr && (v !== 128'h0 || vld !== 1'b0)) begin
          errors++; $display("FAIL rand%0d_rk%0d got %h/%b want 0/0", it, r, v, vld); end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_illegal();
    test_ignore_midrun();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
